apb_regs_hw: RTL and testbench

Parametrised successor to the APB register file. It adds per-register access modes (RW, RO, W1C), configurable wait-state insertion via an access FSM, and a hardware write port so logic can post status into registers. It sits behind an APB demux as a control/status block and drives registered outputs into the peripheral datapath.

---
 rtl/apb_regs_hw.sv | 104 ++++++++++
 tb/tb_apb_regs_hw.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_regs_hw.sv
// apb_regs_hw: APB register file with per-register RW/RO/W1C modes, wait-state
// insertion and a hardware write port for posting status into the registers.
module apb_regs_hw #(
   parameter int                     NO_APB_REGS     = 32,
   parameter int                     ADDR_OFFSET     = 4,
   parameter int                     APB_ADDR_WIDTH  = 32,
   parameter int                     APB_DATA_WIDTH  = 32,
   parameter int                     REG_DATA_WIDTH  = 32,
   parameter logic [NO_APB_REGS-1:0] READ_ONLY       = '0,
   parameter logic [NO_APB_REGS-1:0] WRITE_1_CLEAR   = '0,
   parameter int                     WAIT_CYCLES     = 0,
   parameter bit                     ERR_ON_RO_WRITE = 1'b1
) (
   input  logic                                         pclk_i,
   input  logic                                         preset_ni,
   input  logic [APB_ADDR_WIDTH-1:0]                    paddr_i,
   input  logic                                         psel_i,
   input  logic                                         penable_i,
   input  logic                                         pwrite_i,
   input  logic [APB_DATA_WIDTH-1:0]                    pwdata_i,
   input  logic [(APB_DATA_WIDTH+7)/8-1:0]              pstrb_i,
   output logic                                         pready_o,
   output logic [APB_DATA_WIDTH-1:0]                    prdata_o,
   output logic                                         pslverr_o,
   input  logic [APB_ADDR_WIDTH-1:0]                    base_addr_i,
   input  logic [NO_APB_REGS-1:0][REG_DATA_WIDTH-1:0]   reg_init_i,
   input  logic [NO_APB_REGS-1:0]                       hw_wr_en_i,
   input  logic [NO_APB_REGS-1:0][REG_DATA_WIDTH-1:0]   hw_wr_data_i,
   output logic [NO_APB_REGS-1:0][REG_DATA_WIDTH-1:0]   reg_q_o
);
   localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [0:0]                state;
   logic [CW-1:0]             cnt;
   logic                      access, done, in_range, ro_hit;
   logic [APB_ADDR_WIDTH-1:0] idx;
   logic [NO_APB_REGS-1:0]    sel, wr;
   logic [REG_DATA_WIDTH-1:0] rdata, bmask, wdata;

   if (REG_DATA_WIDTH > APB_DATA_WIDTH) begin : g_bad_width
      $error("REG_DATA_WIDTH must not exceed APB_DATA_WIDTH");
   end
   if ((READ_ONLY & WRITE_1_CLEAR) != '0) begin : g_bad_mode
      $error("a register cannot be both READ_ONLY and WRITE_1_CLEAR");
   end

   assign access   = psel_i & penable_i;
   assign idx      = (paddr_i - base_addr_i) / APB_ADDR_WIDTH'(ADDR_OFFSET);
   assign done     = WAIT_CYCLES == 0 ? access : access && state == ST_WAIT && cnt == CW'(WAIT_CYCLES);
   assign in_range = |sel;
   assign ro_hit   = |(sel & READ_ONLY);
   assign wr       = sel & {NO_APB_REGS{done & pwrite_i}};
   assign wdata    = pwdata_i[REG_DATA_WIDTH-1:0];

   // one-hot select doubles as the read mux; out-of-range leaves it all zero
   always_comb begin
      sel   = '0;
      rdata = '0;
      for (int i = 0; i < NO_APB_REGS; i++) begin
         sel[i] = paddr_i >= base_addr_i && idx == APB_ADDR_WIDTH'(i);
         rdata  = rdata | (sel[i] ? reg_q_o[i] : '0);
      end
   end

   always_comb
      for (int j = 0; j < REG_DATA_WIDTH; j++) bmask[j] = pstrb_i[j / 8];

   assign pready_o  = done;
   assign pslverr_o = done & (!in_range | (pwrite_i & ro_hit & ERR_ON_RO_WRITE));

   always_comb begin
      prdata_o = '0;
      if (done && !pwrite_i && in_range) prdata_o[REG_DATA_WIDTH-1:0] = rdata;
   end

   // an aborted access (psel/penable dropped mid-wait) falls back to IDLE here
   always_ff @(posedge pclk_i or negedge preset_ni)
      if (!preset_ni) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (WAIT_CYCLES == 0 || !access || done) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (state == ST_IDLE) begin
         state <= ST_WAIT;
         cnt   <= CW'(1);
      end else
         cnt <= cnt + 1'b1;

   // W1C: hardware set beats APB clear; RW: APB write beats hardware write
   always_ff @(posedge pclk_i or negedge preset_ni)
      if (!preset_ni)
         reg_q_o <= reg_init_i;
      else
         for (int i = 0; i < NO_APB_REGS; i++)
            if (WRITE_1_CLEAR[i])
               reg_q_o[i] <= reg_q_o[i] & ~(wr[i] ? bmask & wdata : '0) | (hw_wr_en_i[i] ? hw_wr_data_i[i] : '0);
            else if (wr[i] && !READ_ONLY[i])
               reg_q_o[i] <= reg_q_o[i] & ~bmask | wdata & bmask;
            else if (hw_wr_en_i[i])
               reg_q_o[i] <= hw_wr_data_i[i];
endmodule

// File: tb/tb_apb_regs_hw.sv
// tb_apb_regs_hw: three register files (0, 2 and 3 wait states) driven with directed and
// random APB plus hardware writes, compared each cycle against a behavioural model.
module tb_apb_regs_hw;
   localparam int          NR   = 8;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [7:0]  RO   = 8'h10;
   localparam logic [7:0]  WC   = 8'h60;

   logic clk, rst_n;
   logic psel [3], pen [3], pwr [3], done_flag [3];
   logic [31:0] paddr [3], pwdata [3];
   logic [3:0] pstrb [3];
   logic [7:0] hw_en [3];
   logic [NR-1:0][31:0] hw_data [3], q [3], m [3];
   logic [NR-1:0][31:0] init;
   logic pready [3], pslverr [3];
   logic [31:0] prdata [3];
   logic [31:0] rd_cap;
   logic err_cap, rdy_cap, hw_rand;
   int vectors = 0, errs = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_regs_hw #(
         .NO_APB_REGS(NR), .READ_ONLY(RO), .WRITE_1_CLEAR(WC),
         .WAIT_CYCLES(g == 0 ? 0 : g + 1), .ERR_ON_RO_WRITE(1'b1)
      ) u_dut (
         .pclk_i(clk), .preset_ni(rst_n), .paddr_i(paddr[g]), .psel_i(psel[g]),
         .penable_i(pen[g]), .pwrite_i(pwr[g]), .pwdata_i(pwdata[g]), .pstrb_i(pstrb[g]),
         .pready_o(pready[g]), .prdata_o(prdata[g]), .pslverr_o(pslverr[g]),
         .base_addr_i(BASE), .reg_init_i(init), .hw_wr_en_i(hw_en[g]),
         .hw_wr_data_i(hw_data[g]), .reg_q_o(q[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wait_of(input int k);
      return k == 0 ? 0 : k + 1;
   endfunction

   function automatic bit decode(input logic [31:0] a, output int idx);
      idx = 0;
      if (a < BASE || (a - BASE) / 4 >= NR) return 1'b0;
      idx = int'((a - BASE) / 4);
      return 1'b1;
   endfunction

   function automatic logic [NR-1:0][31:0] next_regs(input int k);
      logic [NR-1:0][31:0] r;
      logic [31:0] bm;
      int idx;
      bit hit, apb;
      hit = done_flag[k] && pwr[k] && decode(paddr[k], idx);
      for (int b = 0; b < 4; b++) bm[8*b+:8] = {8{pstrb[k][b]}};
      for (int i = 0; i < NR; i++) begin
         apb = hit && idx == i;
         if (RO[i])
            r[i] = hw_en[k][i] ? hw_data[k][i] : m[k][i];
         else if (WC[i])
            r[i] = (apb ? m[k][i] & ~(pwdata[k] & bm) : m[k][i]) | (hw_en[k][i] ? hw_data[k][i] : 32'h0);
         else
            r[i] = apb ? (m[k][i] & ~bm) | (pwdata[k] & bm) : hw_en[k][i] ? hw_data[k][i] : m[k][i];
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) for (int k = 0; k < 3; k++) m[k] <= init;
      else for (int k = 0; k < 3; k++) m[k] <= next_regs(k);

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic compare(input int k);
      int idx;
      bit in_r;
      logic [31:0] ee, er;
      in_r = decode(paddr[k], idx);
      ee = 32'(done_flag[k] && (!in_r || (pwr[k] && RO[idx])));
      er = (done_flag[k] && !pwr[k] && in_r) ? m[k][idx] : 32'h0;
      check($sformatf("pready%0d", k), 32'(pready[k]), 32'(done_flag[k]));
      check($sformatf("pslverr%0d", k), 32'(pslverr[k]), ee);
      check($sformatf("prdata%0d", k), prdata[k], er);
      for (int i = 0; i < NR; i++) check($sformatf("reg_q%0d[%0d]", k, i), q[k][i], m[k][i]);
   endtask

   always @(negedge clk) if (rst_n === 1'b1) for (int k = 0; k < 3; k++) compare(k);

   task automatic apb(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(posedge clk) #1;
      psel[k] = 1'b1; pen[k] = 1'b0; pwr[k] = wr; paddr[k] = a; pwdata[k] = d; pstrb[k] = s;
      @(posedge clk) #1;
      pen[k] = 1'b1;
      for (int c = 0; c < wait_of(k); c++) @(posedge clk) #1;
      done_flag[k] = 1'b1;
      #3;
      rd_cap = prdata[k]; err_cap = pslverr[k]; rdy_cap = pready[k];
      @(posedge clk) #1;
      psel[k] = 1'b0; pen[k] = 1'b0; done_flag[k] = 1'b0;
   endtask

   initial forever begin
      @(posedge clk) #1;
      if (hw_rand)
         for (int k = 0; k < 3; k++) begin
            hw_en[k] = 8'($urandom & $urandom & $urandom);
            for (int i = 0; i < NR; i++) hw_data[k][i] = $urandom;
         end
   end

   initial begin
      hw_rand = 1'b0;
      init = '0;
      init[1] = 32'h1111_0001; init[2] = 32'h2222_0002; init[3] = 32'h0000_BEEF;
      init[4] = 32'h0000_0004; init[5] = 32'h0000_000F; init[6] = 32'h0000_00F0;
      init[7] = 32'hCAFE_0007;
      for (int k = 0; k < 3; k++) begin
         psel[k] = 0; pen[k] = 0; pwr[k] = 0; done_flag[k] = 0;
         paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0; hw_en[k] = '0; hw_data[k] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset reg3", q[0][3], 32'h0000_BEEF);
      check("reset reg0", q[1][0], 32'h0);

      apb(0, 1'b0, BASE + 32'hC, 32'h0, 4'hF);
      check("rd reg3 data", rd_cap, 32'h0000_BEEF);
      check("rd reg3 ready", 32'(rdy_cap), 32'h1);
      check("rd reg3 err", 32'(err_cap), 32'h0);

      apb(1, 1'b1, BASE, 32'h1234_5678, 4'b0101);
      check("strobe write ready", 32'(rdy_cap), 32'h1);
      check("strobe write reg0", q[1][0], 32'h0034_0078);

      apb(0, 1'b1, BASE + 32'h10, 32'h0000_FFFF, 4'hF);
      check("ro write err", 32'(err_cap), 32'h1);
      check("ro write unchanged", q[0][4], 32'h0000_0004);
      hw_en[0] = 8'h10; hw_data[0][4] = 32'hA5;
      @(posedge clk) #1;
      hw_en[0] = 8'h00;
      check("ro hw write", q[0][4], 32'hA5);
      apb(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF);
      check("ro read", rd_cap, 32'hA5);

      hw_en[0] = 8'h20; hw_data[0][5] = 32'h01;
      apb(0, 1'b1, BASE + 32'h14, 32'h03, 4'hF);
      hw_en[0] = 8'h00;
      check("w1c set beats clear", q[0][5], 32'h0D);

      apb(0, 1'b0, BASE + 32'h20, 32'h0, 4'hF);
      check("oor high err", 32'(err_cap), 32'h1);
      check("oor high data", rd_cap, 32'h0);
      apb(0, 1'b1, BASE - 32'h4, 32'hFFFF_FFFF, 4'hF);
      check("oor low wr err", 32'(err_cap), 32'h1);
      apb(0, 1'b0, BASE - 32'h4, 32'h0, 4'hF);
      check("oor low rd err", 32'(err_cap), 32'h1);
      check("oor low rd data", rd_cap, 32'h0);

      hw_rand = 1'b1;
      for (int n = 0; n < 250; n++) begin
         int k, sl;
         logic [31:0] a;
         k = $urandom_range(0, 2);
         sl = $urandom_range(0, 9);
         a = sl < 8 ? BASE + 32'(4 * sl) : sl == 8 ? BASE + 32'h20 : BASE - 32'h4;
         a = a + 32'($urandom_range(0, 3));
         apb(k, 1'($urandom), a, $urandom, 4'($urandom));
      end
      hw_rand = 1'b0;
      @(posedge clk) #1;
      for (int k = 0; k < 3; k++) hw_en[k] = '0;
      @(posedge clk) #1;

      // aborted access on the 3-wait-state instance
      psel[2] = 1; pen[2] = 0; pwr[2] = 1; paddr[2] = BASE + 32'h4; pwdata[2] = 32'hFFFF_FFFF; pstrb[2] = 4'hF;
      @(posedge clk) #1 pen[2] = 1;
      @(posedge clk) #1;
      @(posedge clk) #1;
      psel[2] = 0; pen[2] = 0;
      #3 check("abort ready", 32'(pready[2]), 32'h0);
      @(posedge clk) #1;
      check("abort no commit", q[2][1], m[2][1]);
      psel[2] = 1; pen[2] = 0;
      @(posedge clk) #1 pen[2] = 1;
      @(posedge clk) #1 rst_n = 1'b0;
      #2;
      check("rst mid ready", 32'(pready[2]), 32'h0);
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < NR; i++) check($sformatf("rst mid reg%0d[%0d]", k, i), q[k][i], init[i]);
      psel[2] = 0; pen[2] = 0;
      @(posedge clk) #1 rst_n = 1'b1;
      check("post rst reg1", q[2][1], 32'h1111_0001);
      apb(2, 1'b1, BASE + 32'h8, 32'h0000_5A5A, 4'b0011);
      check("post rst write ready", 32'(rdy_cap), 32'h1);
      check("post rst write", q[2][2], 32'h2222_5A5A);
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
